// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter and one-hot slave decoder for the system bus.
// Ports: clock/reset, imem_* fetch port, dmem_* load/store port, bus_* slave side.
module bus_arbiter #(
  parameter logic [31:0] ROM_BASE   = 32'h00000000,
  parameter logic [31:0] ROM_MASK   = 32'h000000FF,
  parameter logic [31:0] SPI_BASE   = 32'h00100000,
  parameter logic [31:0] SPI_MASK   = 32'h000FFFFF,
  parameter logic [31:0] UART_BASE  = 32'h01000000,
  parameter logic [31:0] UART_MASK  = 32'h0000001F,
  parameter logic [31:0] CLINT_BASE = 32'h02000000,
  parameter logic [31:0] CLINT_MASK = 32'h0000FFFF,
  parameter logic [31:0] RAM_BASE   = 32'h80000000,
  parameter logic [31:0] RAM_MASK   = 32'h000FFFFF,
  parameter int          TIMEOUT    = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_error,
  output logic        bus_valid,
  output logic        bus_instr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  output logic [4:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic          instr_q;
  logic [4:0]    sel_q;
  logic          last_instr;

  logic          req_any;
  logic          grant_instr;
  logic [31:0]   req_addr;
  logic [4:0]    hit;
  logic [4:0]    sel_nx;
  logic          expired;

  assign req_any     = imem_valid | dmem_valid;
  // On a tie the master that did not win last time gets the bus.
  assign grant_instr = imem_valid & (~dmem_valid | ~last_instr);
  assign req_addr    = grant_instr ? imem_addr : dmem_addr;

  assign hit[0] = (req_addr & ~ROM_MASK)   == ROM_BASE;
  assign hit[1] = (req_addr & ~SPI_MASK)   == SPI_BASE;
  assign hit[2] = (req_addr & ~UART_MASK)  == UART_BASE;
  assign hit[3] = (req_addr & ~CLINT_MASK) == CLINT_BASE;
  assign hit[4] = (req_addr & ~RAM_MASK)   == RAM_BASE;

  // Isolate lowest set bit so overlaps pick the lowest slave index.
  assign sel_nx  = hit & (~hit + 5'd1);
  assign expired = timer == TW'(TIMEOUT - 1);

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_instr = instr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      instr_q    <= 1'b0;
      sel_q      <= '0;
      last_instr <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_any) begin
        addr_q     <= req_addr;
        wdata_q    <= grant_instr ? 32'd0 : dmem_wdata;
        wstrb_q    <= grant_instr ? 4'd0 : dmem_wstrb;
        instr_q    <= grant_instr;
        sel_q      <= sel_nx;
        last_instr <= grant_instr;
        timer      <= '0;
      end else if (state == BUSY && !bus_ready) begin
        timer <= timer + TW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_any) state_nx = (|hit) ? BUSY : ERR;
      BUSY: begin
        if (bus_ready)    state_nx = IDLE;
        else if (expired) state_nx = ERR;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus_valid  = 1'b0;
    bus_sel    = '0;
    bus_wstrb  = '0;
    imem_ready = 1'b0;
    imem_error = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_error = 1'b0;
    dmem_rdata = '0;
    unique case (state)
      BUSY: begin
        bus_valid = 1'b1;
        bus_sel   = sel_q;
        bus_wstrb = wstrb_q;
        if (bus_ready) begin
          if (instr_q) begin
            imem_ready = 1'b1;
            imem_rdata = bus_rdata;
          end else begin
            dmem_ready = 1'b1;
            dmem_rdata = bus_rdata;
          end
        end
      end
      ERR: begin
        if (instr_q) begin
          imem_ready = 1'b1;
          imem_error = 1'b1;
        end else begin
          dmem_ready = 1'b1;
          dmem_error = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
